// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO in front of a START/DATA/STOP serialiser.
// Latency: a read is answered one cycle after the request; a DATA write to an idle line drops txd two cycles later.
// Backpressure: none on the bus; a DATA write to a full FIFO is dropped and latches the sticky ovf flag.
//
// Ports:
//   clk    - single clock
//   rst    - asynchronous active-low reset; forces txd high at once and discards queued bytes
//   oe     - one-cycle bus access strobe
//   addr   - byte address; 0xf0000100 = DATA, 0xf0000104 = STAT, anything else is ignored
//   wdata  - write data; [7:0] is the byte for DATA, [2] is the ovf clear bit for STAT
//   we     - byte write enables; any nonzero value makes the access a write
//   rdata  - read data, nonzero only while ready is high
//   ready  - one-cycle read response pulse
//   txd    - serial output, idles high
//   busy   - FIFO non-empty or a frame in flight
//
// Parameter ranges: 2 <= DIV <= 65535, 1 <= FIFO_LOG2 <= 7.

module mmio_uart_tx #(
   parameter int unsigned DIV       = 868,
   parameter int unsigned FIFO_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        oe,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  we,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        txd,
   output logic        busy
);

   localparam int unsigned DEPTH     = 1 << FIFO_LOG2;
   localparam int unsigned PW        = FIFO_LOG2 + 1;
   localparam logic [31:0] ADDR_DATA = 32'hf000_0100;
   localparam logic [31:0] ADDR_STAT = 32'hf000_0104;
   localparam logic [15:0] BAUD_LAST = 16'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic sel_data;
   logic sel_stat;
   logic is_wr;
   logic rd_req;
   logic push_req;
   logic push;
   logic pop;

   assign is_wr    = |we;
   assign sel_data = oe && (addr == ADDR_DATA);
   assign sel_stat = oe && (addr == ADDR_STAT);
   assign rd_req   = (sel_data || sel_stat) && !is_wr;
   assign push_req = sel_data && is_wr;

   // Only the low byte carries data; the rest of the write bus is ignored.
   logic unused_wdata;
   assign unused_wdata = ^wdata[31:8];

   // ------------------------------------------------------------------
   // Byte FIFO: pointers carry one extra wrap bit so full and empty are
   // distinguishable without a separate occupancy counter.
   // ------------------------------------------------------------------
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] fill;
   logic [7:0]    count8;
   logic [7:0]    head;
   logic          fifo_full;
   logic          fifo_empty;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign fill       = wr_ptr - rd_ptr;
   assign count8     = 8'(fill);
   assign head       = mem[rd_ptr[PW-2:0]];

   // Full is judged on the pre-edge state, so a push that coincides with a
   // pop from a full FIFO is still dropped.
   assign push = push_req && !fifo_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PW-2:0]] <= wdata[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Sticky overflow flag; a drop in the same cycle wins over a clear.
   // ------------------------------------------------------------------
   logic ovf;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (push_req && fifo_full) begin
         ovf <= 1'b1;
      end else if (sel_stat && is_wr && wdata[2]) begin
         ovf <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Serialiser
   // ------------------------------------------------------------------
   state_t      state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        baud_last;

   assign baud_last = (baud_cnt == BAUD_LAST);

   // The head byte is taken either from idle or on the final STOP cycle,
   // which is what makes queued frames run back to back with no idle gap.
   assign pop = !fifo_empty &&
                ((state == S_IDLE) || ((state == S_STOP) && baud_last));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         txd      <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               txd <= 1'b1;
               if (pop) begin
                  state    <= S_START;
                  shreg    <= head;
                  baud_cnt <= '0;
                  txd      <= 1'b0;
               end
            end

            S_START: begin
               if (baud_last) begin
                  state    <= S_DATA;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  txd      <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     txd   <= 1'b1;
                  end else begin
                     // Shift and present the next bit in the same edge so
                     // shreg[0] always holds the bit currently on the line.
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            S_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     state <= S_START;
                     shreg <= head;
                     txd   <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                     txd   <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            default: begin
               state    <= S_IDLE;
               baud_cnt <= '0;
               txd      <= 1'b1;
            end
         endcase
      end
   end

   assign busy = !fifo_empty || (state != S_IDLE);

   // ------------------------------------------------------------------
   // Read response: status is captured from the request cycle's pre-edge
   // state and presented for exactly one cycle.
   // ------------------------------------------------------------------
   logic        fsm_active;
   logic [31:0] rd_val;

   assign fsm_active = (state != S_IDLE);

   always_comb begin
      rd_val = '0;
      if (sel_stat) begin
         rd_val = {16'b0, count8, 5'b0, ovf, fsm_active, fifo_empty};
      end else begin
         rd_val = {31'b0, !fifo_full};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= rd_req;
         rdata <= rd_req ? rd_val : 32'b0;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

   localparam int D     = 4;
   localparam int LG    = 2;
   localparam int DEPTH = 4;
   localparam int FL    = 10 * D;
   localparam logic [31:0] A_DATA = 32'hf000_0100;
   localparam logic [31:0] A_STAT = 32'hf000_0104;

   logic        clk;
   logic        rst;
   logic        oe;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  we;
   logic [31:0] rdata;
   logic        ready;
   logic        txd;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mmio_uart_tx #(.DIV(D), .FIFO_LOG2(LG)) dut (
      .clk   (clk),
      .rst   (rst),
      .oe    (oe),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .rdata (rdata),
      .ready (ready),
      .txd   (txd),
      .busy  (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------------
   // Reference model: a queue of accepted bytes plus the start cycle of the
   // frame on the line. The line waveform is derived arithmetically from it.
   // ------------------------------------------------------------------
   logic [7:0]  q[$];
   bit          m_ovf;
   bit          fr_vld;
   int          fr_start;
   logic [7:0]  fr_byte;
   int          cyc;
   logic        exp_ready;
   logic [31:0] exp_rdata;

   function automatic bit m_active(int c);
      return fr_vld && (c >= fr_start) && (c < fr_start + FL);
   endfunction

   function automatic logic m_txd(int c);
      int pos;
      if (!m_active(c)) return 1'b1;
      pos = (c - fr_start) / D;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return fr_byte[pos-1];
      return 1'b1;
   endfunction

   function automatic logic m_busy(int c);
      return (q.size() != 0) || m_active(c);
   endfunction

   // Advance one clock: apply this cycle's inputs to the model, then move to
   // 1 time unit after the next rising edge.
   task automatic tick();
      bit          sel_d;
      bit          sel_s;
      bit          wr;
      bit          full;
      bit          pop;
      logic [31:0] rv;
      if (rst !== 1'b1) begin
         q.delete();
         m_ovf     = 1'b0;
         fr_vld    = 1'b0;
         exp_ready = 1'b0;
         exp_rdata = 32'h0;
      end else begin
         sel_d = oe && (addr == A_DATA);
         sel_s = oe && (addr == A_STAT);
         wr    = (we != 4'h0);
         full  = (q.size() == DEPTH);
         rv    = 32'h0;
         if (sel_d && !wr) rv = {31'b0, !full};
         if (sel_s && !wr) rv = {16'b0, 8'(q.size()), 5'b0, m_ovf, m_active(cyc), q.size() == 0};
         exp_ready = (sel_d || sel_s) && !wr;
         exp_rdata = rv;
         pop = (q.size() != 0) && (!fr_vld || cyc >= fr_start + FL - 1);
         if (pop) begin
            fr_byte  = q.pop_front();
            fr_start = cyc + 1;
            fr_vld   = 1'b1;
         end
         if (sel_d && wr) begin
            if (full) m_ovf = 1'b1;
            else q.push_back(wdata[7:0]);
         end else if (sel_s && wr && wdata[2]) begin
            m_ovf = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic bus_idle();
      oe    = 1'b0;
      we    = 4'h0;
      addr  = 32'h0;
      wdata = 32'h0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      oe    = 1'b1;
      addr  = a;
      wdata = d;
      we    = 4'hf;
      tick();
      bus_idle();
   endtask

   task automatic bus_read(input logic [31:0] a);
      oe    = 1'b1;
      addr  = a;
      wdata = $urandom;
      we    = 4'h0;
      tick();
      bus_idle();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      oe  = 1'b1;
      addr = A_STAT;
      we  = 4'h0;
      wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (txd !== 1'b1 || ready !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d txd=%b ready=%b rdata=%h busy=%b want 1 0 0 0",
                     cyc, txd, ready, rdata, busy);
         end
      end
      rst = 1'b1;
      tick();
      bus_idle();
      checks++;
      if (ready !== 1'b1 || rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_stat cyc=%0d ready=%b rdata=%h want 1 00000001", cyc, ready, rdata);
      end
      tick();
      checks++;
      if (ready !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata_clear ready=%b rdata=%h want 0 00000000", ready, rdata);
      end
   endtask

   task automatic test_single();
      int   n;
      logic e;
      n = cyc;
      bus_write(A_DATA, 32'h55);
      while (cyc <= n + 43) begin
         checks++;
         if (txd !== m_txd(cyc)) begin
            errors++;
            $display("FAIL single_txd_model cyc=%0d got=%b want=%b", cyc - n, txd, m_txd(cyc));
         end
         e = 1'b1;
         if (cyc >= n + 2 && cyc <= n + 5) e = 1'b0;
         else if (cyc >= n + 6 && cyc <= n + 37) e = (((cyc - n - 6) / 4) % 2 == 0);
         checks++;
         if (txd !== e) begin
            errors++;
            $display("FAIL single_txd_pattern cyc=N+%0d got=%b want=%b", cyc - n, txd, e);
         end
         if (cyc == n + 41 || cyc == n + 42) begin
            checks++;
            if (busy !== (cyc == n + 41)) begin
               errors++;
               $display("FAIL single_busy cyc=N+%0d got=%b want=%b", cyc - n, busy, cyc == n + 41);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int first;
      int second;
      n = cyc;
      first = -1;
      second = -1;
      oe = 1'b1; addr = A_DATA; we = 4'hf;
      wdata = 32'h41;
      tick();
      wdata = 32'h42;
      tick();
      bus_idle();
      while (cyc <= n + 85) begin
         checks++;
         if (txd !== m_txd(cyc) || busy !== m_busy(cyc)) begin
            errors++;
            $display("FAIL b2b_model cyc=N+%0d txd=%b busy=%b want %b %b",
                     cyc - n, txd, busy, m_txd(cyc), m_busy(cyc));
         end
         if (first < 0 && txd === 1'b0) first = cyc;
         else if (first >= 0 && second < 0 && cyc >= first + 36 && txd === 1'b0) second = cyc;
         tick();
      end
      checks++;
      if (first != n + 2 || second != first + 40) begin
         errors++;
         $display("FAIL b2b_start_spacing first=N+%0d second=N+%0d want N+2 N+42", first - n, second - n);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b [6];
      b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
      oe = 1'b1; addr = A_DATA; we = 4'hf;
      for (int i = 0; i < 6; i++) begin
         wdata = {24'h0, b[i]};
         tick();
      end
      bus_idle();
      bus_read(A_STAT);
      checks++;
      if (ready !== 1'b1 || rdata !== 32'h0000_0406 || rdata !== exp_rdata) begin
         errors++;
         $display("FAIL ovf_stat ready=%b rdata=%h want 1 00000406 model=%h", ready, rdata, exp_rdata);
      end
      bus_read(A_DATA);
      checks++;
      if (ready !== 1'b1 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL ovf_data_full ready=%b rdata=%h want 1 00000000", ready, rdata);
      end
   endtask

   task automatic test_clear_status();
      int guard;
      bus_write(A_STAT, 32'h4);
      bus_read(A_STAT);
      checks++;
      if (ready !== 1'b1 || rdata[2] !== 1'b0 || rdata !== 32'h0000_0402 || rdata !== exp_rdata) begin
         errors++;
         $display("FAIL clear_ovf rdata=%h want 00000402 model=%h", rdata, exp_rdata);
      end
      guard = 0;
      while (busy === 1'b1 && guard < 400) begin
         checks++;
         if (txd !== m_txd(cyc)) begin
            errors++;
            $display("FAIL drain_txd cyc=%0d got=%b want=%b", cyc, txd, m_txd(cyc));
         end
         tick();
         guard++;
      end
      checks++;
      if (busy !== 1'b0 || guard < 150) begin
         errors++;
         $display("FAIL drain_time busy=%b cycles=%0d want 0 and 150..399", busy, guard);
      end
      bus_read(A_DATA);
      checks++;
      if (ready !== 1'b1 || rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL data_rd_avail ready=%b rdata=%h want 1 00000001", ready, rdata);
      end
   endtask

   task automatic test_random();
      int r;
      int b;
      int hi;
      int guard;
      for (int i = 0; i < 1500; i++) begin
         hi = ((i / 300) % 2 == 1) ? 15 : 80;
         r = $urandom_range(0, hi);
         oe = 1'b0; we = 4'h0; addr = $urandom; wdata = $urandom;
         if (r <= 1) begin
            oe = 1'b1; addr = A_DATA; we = 4'($urandom_range(1, 15));
         end else if (r == 2) begin
            oe = 1'b1; addr = A_STAT;
         end else if (r == 3) begin
            oe = 1'b1; addr = A_DATA;
         end else if (r == 4) begin
            oe = 1'b1; addr = A_STAT; we = 4'($urandom_range(1, 15));
         end else if (r == 5) begin
            b = $urandom_range(0, 31);
            if (b == 2) b = 3;
            oe = 1'b1; addr = A_DATA ^ (32'd1 << b); we = 4'($urandom_range(0, 15));
         end
         tick();
         checks++;
         if (txd !== m_txd(cyc) || busy !== m_busy(cyc)) begin
            errors++;
            $display("FAIL rand_line cyc=%0d txd=%b busy=%b want %b %b", cyc, txd, busy, m_txd(cyc), m_busy(cyc));
         end
         checks++;
         if (ready !== exp_ready || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL rand_read cyc=%0d ready=%b rdata=%h want %b %h", cyc, ready, rdata, exp_ready, exp_rdata);
         end
      end
      bus_idle();
      guard = 0;
      while (busy === 1'b1 && guard < 600) begin
         checks++;
         if (txd !== m_txd(cyc)) begin
            errors++;
            $display("FAIL rand_drain cyc=%0d txd=%b want %b", cyc, txd, m_txd(cyc));
         end
         tick();
         guard++;
      end
      checks++;
      if (busy !== 1'b0 || m_busy(cyc) !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain_done busy=%b model=%b want 0", busy, m_busy(cyc));
      end
   endtask

   task automatic test_midframe_reset();
      int n;
      n = cyc;
      bus_write(A_DATA, 32'hF0);
      bus_write(A_DATA, 32'h11);
      bus_write(A_DATA, 32'h22);
      while (cyc < n + 19) begin
         checks++;
         if (txd !== m_txd(cyc)) begin
            errors++;
            $display("FAIL mid_pre_txd cyc=N+%0d got=%b want=%b", cyc - n, txd, m_txd(cyc));
         end
         tick();
      end
      checks++;
      if (txd !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_bit3 txd=%b busy=%b want 0 1", txd, busy);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_async_reset txd=%b busy=%b ready=%b want 1 0 0", txd, busy, ready);
      end
      tick();
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_reset cyc=%0d txd=%b busy=%b want 1 0", i, txd, busy);
         end
      end
      bus_read(A_STAT);
      checks++;
      if (ready !== 1'b1 || rdata !== 32'h0000_0001) begin
         errors++;
         $display("FAIL mid_stat ready=%b rdata=%h want 1 00000001", ready, rdata);
      end
   endtask

   initial begin
      cyc = 0;
      m_ovf = 1'b0;
      fr_vld = 1'b0;
      fr_start = 0;
      fr_byte = 8'h0;
      exp_ready = 1'b0;
      exp_rdata = 32'h0;
      rst = 1'b0;
      bus_idle();
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_clear_status();
      test_random();
      test_midframe_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter: the console peripheral on the processor data bus at 0xf0000100. It accepts byte writes into a FIFO and serialises them 8N1 on `txd`. It returns a TX-available status on reads, so software polling works the same on hardware as it does in simulation. It sits beside data memory on the `mem_*` bus, and the top level ORs its `ready`/`rdata` into the bus response mux.

## Interface
- `DIV`, 868: clock cycles per UART bit. Must satisfy 2 ≤ `DIV` ≤ 65535.
- `FIFO_LOG2`, 4: FIFO depth is 2**`FIFO_LOG2` entries, each 8 bits wide. Must satisfy 1 ≤ `FIFO_LOG2` ≤ 7.

- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous and active-low.
- `oe`  in  1  bus access strobe, valid for one cycle per request.
- `addr`  in  32  byte address of the access.
- `wdata`  in  32  write data; only bits [7:0] are used.
- `we`  in  4  byte write enables. Any nonzero value makes the access a write.
- `rdata`  out  32  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle read response pulse.
- `txd`  out  1  serial output; idles high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in flight.

## Operation
- Decode: the block is selected when `oe`=1 and `addr` equals 0xf0000100 (DATA) or 0xf0000104 (STAT). All other addresses are ignored; no response, no side effect.
- DATA write: pushes `wdata[7:0]` if the FIFO is not full. If the FIFO is full, the byte is dropped and the sticky `ovf` bit is set.
- Full check: "full" is the pre-edge state. A push arriving in the same cycle as a pop from a full FIFO is still dropped.
- DATA read: `rdata` = {31'b0, !full}, with full sampled in the request cycle.
- STAT read: `rdata` = {16'b0, count[7:0], 5'b0, ovf, fsm_active, empty}. `count` is the current FIFO occupancy, 0..2**`FIFO_LOG2`.
- STAT write: if `wdata[2]`=1, `ovf` is cleared (write-1-to-clear). If a DATA overflow cannot coexist in the same cycle, no conflict arises; the set path still takes priority over the clear.
- Writes produce no `ready` pulse. Reads produce exactly one.
- Serialiser FSM states:
  - IDLE: `txd`=1. Moves to START when the FIFO is non-empty, popping the head byte into the shift register on that edge.
  - START: `txd`=0 for `DIV` cycles.
  - DATA: 8 bits, LSB first, `DIV` cycles each, tracked by a 3-bit bit index.
  - STOP: `txd`=1 for `DIV` cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Counters:
  - Baud counter: 16 bits, counts 0..`DIV`-1, and restarts at 0 on every state entry.
  - FIFO pointers: `FIFO_LOG2`+1 bits, wrapping. full = MSBs differ and LSBs equal; empty = pointers equal.
- `busy` = !empty | (state != IDLE).

## Timing
- Reset (asynchronous, while `rst`=0):
  - Outputs: `txd`=1, `ready`=0, `rdata`=0, `busy`=0.
  - Internal: FSM=IDLE, FIFO empty, `ovf`=0, counters=0.
- Reset asserted mid-frame: the frame is aborted and `txd` goes high immediately, without waiting for a clock edge. Queued bytes are discarded.
- Read latency: request in cycle N gives `ready`=1 with `rdata` valid in cycle N+1, held for one cycle only. `rdata` returns to 0 when `ready`=0.
- Back-to-back reads in consecutive cycles give consecutive `ready` pulses.
- Write to idle path: the DATA write edge at the end of cycle N leaves the FIFO non-empty in N+1. The IDLE→START edge is at the end of N+1, so `txd` falls in cycle N+2.
- Frame length is exactly 10·`DIV` cycles. Consecutive queued bytes are sent with zero gap between frames.
- Pop and push in the same cycle on a non-full FIFO: both take effect and `count` is unchanged.
- STAT read in the same cycle as a push or pop reports the pre-edge `count`.

## Test plan
- Reset with `DIV`=4, `FIFO_LOG2`=2: hold `rst`=0 for 3 cycles while driving `oe`. Expect `txd`=1 and `ready`=0 throughout; after release, a STAT read returns 0x00000001.
- Single byte: write 0x55 to 0xf0000100 in cycle N. Expect `txd` low from N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. `busy` falls at N+42.
- Back-to-back: write 0x41 then 0x42 in consecutive cycles. Expect the second start bit exactly 40 cycles after the first start bit, with no idle-high cycle between frames.
- Overflow: write 6 bytes in consecutive cycles with depth 4. Expect bytes 1–5 queued (byte 1 is popped into the shifter first) and byte 6 dropped. STAT then reads `ovf`=1, count=4; a DATA read returns 0 until the next pop.
- Clear and status: write 0x4 to 0xf0000104, then read STAT. Expect `ovf`=0. Read 0xf0000100 after drain; expect `rdata`=1 one cycle after the request.
- Mid-frame reset: assert `rst`=0 during DATA bit 3 with 2 bytes queued. Expect `txd`=1 within the same cycle. After release, expect no further frames and STAT = 0x00000001.
